// File: rtl/axi_wr_burst_ctrl_if.sv
// ============================================================================
// axi_wr_burst_ctrl_if : FIFO, write-master and status signals of the burst
//                        scheduler
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface axi_wr_burst_ctrl_if #(
  parameter int AXI_WIDTH  = 256,
  parameter int FIFO_CNT_W = 10
);
  logic [FIFO_CNT_W-1:0] fifo_rd_count;
  logic [AXI_WIDTH-1:0]  fifo_rd_data;
  logic                  fifo_rd_en;
  logic                  wr_start;
  logic [28:0]           wr_addr;
  logic [7:0]            wr_len;
  logic [AXI_WIDTH-1:0]  wr_data;
  logic                  wr_ready;
  logic                  wr_done;
  logic                  m_axi_w_handshake;
  logic                  busy;
  logic                  wrap_pulse;

  modport master (
    input  fifo_rd_count, fifo_rd_data, wr_ready, wr_done, m_axi_w_handshake,
    output fifo_rd_en, wr_start, wr_addr, wr_len, wr_data, busy, wrap_pulse
  );

  modport slave (
    output fifo_rd_count, fifo_rd_data, wr_ready, wr_done, m_axi_w_handshake,
    input  fifo_rd_en, wr_start, wr_addr, wr_len, wr_data, busy, wrap_pulse
  );
endinterface

`default_nettype wire

// File: rtl/axi_wr_burst_ctrl.sv
// ============================================================================
// axi_wr_burst_ctrl : schedules fixed-length write bursts from a show-ahead
//                     FIFO into a circular DDR frame region
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module axi_wr_burst_ctrl #(
  parameter int          AXI_WIDTH    = 256,
  parameter logic [7:0]  WR_BURST_LEN = 8'd31,
  parameter logic [28:0] ADDR_BEGIN   = 29'h0,
  parameter logic [28:0] ADDR_END     = 29'h1000,
  parameter int          FIFO_CNT_W   = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_en,
  input  logic                 frame_rst,
  axi_wr_burst_ctrl_if.master  bus
);

  localparam int          BEATS           = int'(WR_BURST_LEN) + 1;
  localparam int          BURST_BYTES_INT = BEATS * (AXI_WIDTH / 8);
  localparam logic [28:0] BURST_BYTES     = 29'(BURST_BYTES_INT);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START     = 2'd1,
    WAIT_DONE = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic        start_c;
  logic        busy_c;
  logic [28:0] addr;
  logic        pending;
  logic        wrap;
  logic [29:0] addr_sum;
  logic        burst_ready;
  logic        done_evt;

  assign burst_ready = 32'(bus.fifo_rd_count) >= 32'(BEATS);
  assign done_evt    = (state == WAIT_DONE) && bus.wr_done;
  // one extra bit so the region-end compare cannot alias on overflow
  assign addr_sum    = {1'b0, addr} + {1'b0, BURST_BYTES};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    start_c   = 1'b0;
    busy_c    = 1'b0;
    case (state)
      IDLE: begin
        if (wr_en && bus.wr_ready && burst_ready && !frame_rst && !pending) begin
          state_nxt = START;
        end
      end
      START: begin
        start_c   = 1'b1;
        state_nxt = WAIT_DONE;
      end
      WAIT_DONE: begin
        busy_c = 1'b1;
        if (bus.wr_done) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // A frame restart during a burst is deferred so the burst lands where it began.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr    <= ADDR_BEGIN;
      pending <= 1'b0;
      wrap    <= 1'b0;
    end else begin
      wrap <= 1'b0;
      if (done_evt) begin
        pending <= 1'b0;
        if (pending || frame_rst) begin
          addr <= ADDR_BEGIN;
        end else if (addr_sum >= {1'b0, ADDR_END}) begin
          addr <= ADDR_BEGIN;
          wrap <= 1'b1;
        end else begin
          addr <= addr_sum[28:0];
        end
      end else if (frame_rst) begin
        if (state == IDLE) begin
          addr <= ADDR_BEGIN;
        end else begin
          pending <= 1'b1;
        end
      end
    end
  end

  assign bus.wr_start   = start_c;
  assign bus.busy       = busy_c;
  assign bus.wr_addr    = addr;
  assign bus.wr_len     = WR_BURST_LEN;
  assign bus.wr_data    = bus.fifo_rd_data;
  assign bus.fifo_rd_en = bus.m_axi_w_handshake && (state == WAIT_DONE);
  assign bus.wrap_pulse = wrap;

endmodule

`default_nettype wire

// File: tb/tb_axi_wr_burst_ctrl.sv
// ============================================================================
// tb_axi_wr_burst_ctrl : scoreboard bench for axi_wr_burst_ctrl
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_axi_wr_burst_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic wr_en = 1'b0;
  logic frame_rst = 1'b0;

  axi_wr_burst_ctrl_if #(.AXI_WIDTH(256), .FIFO_CNT_W(10)) bus ();

  axi_wr_burst_ctrl u_dut (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .frame_rst (frame_rst),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  int          total = 0;
  int          bad   = 0;
  logic [28:0] model_addr    = 29'h0;
  bit          model_pending = 1'b0;
  logic [28:0] addr_q[$];

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_burst(input bit drop_en, input bit frame_mid);
    int          lat;
    int          pops;
    bit          exp_wrap;
    logic [255:0] d;
    logic [28:0] exp_addr;
    addr_q.push_back(model_addr);
    bus.fifo_rd_count = 10'd32;
    wr_en        = 1'b1;
    bus.wr_ready = 1'b1;
    lat = 0;
    while (bus.wr_start !== 1'b1 && lat < 8) begin
      tick();
      lat++;
    end
    chk("start_lat", 256'(lat), 256'(1));
    if (bus.wr_start !== 1'b1) begin
      void'(addr_q.pop_front());
      return;
    end
    exp_addr = addr_q.pop_front();
    chk("wr_addr", 256'(bus.wr_addr), 256'(exp_addr));
    chk("wr_len", 256'(bus.wr_len), 256'(31));
    chk("busy_start", 256'(bus.busy), 256'(0));
    bus.fifo_rd_count = 10'd0;
    tick();
    chk("start_pulse", 256'(bus.wr_start), 256'(0));
    chk("busy", 256'(bus.busy), 256'(1));
    if (drop_en) wr_en = 1'b0;
    if (frame_mid) begin
      frame_rst = 1'b1;
      tick();
      frame_rst = 1'b0;
      model_pending = 1'b1;
    end
    pops = 0;
    for (int i = 0; i < 32; i++) begin
      d = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      bus.fifo_rd_data      = d;
      bus.m_axi_w_handshake = 1'b1;
      #1;
      if (bus.fifo_rd_en === 1'b1) pops++;
      if (i == 0 || i == 31) chk("wr_data", bus.wr_data, d);
      tick();
    end
    bus.m_axi_w_handshake = 1'b0;
    chk("pops", 256'(pops), 256'(32));
    chk("addr_stable", 256'(bus.wr_addr), 256'(exp_addr));
    bus.wr_done = 1'b1;
    tick();
    bus.wr_done = 1'b0;
    exp_wrap = 1'b0;
    if (model_pending) begin
      model_addr    = 29'h0;
      model_pending = 1'b0;
    end else if (model_addr + 29'h400 >= 29'h1000) begin
      model_addr = 29'h0;
      exp_wrap   = 1'b1;
    end else begin
      model_addr = model_addr + 29'h400;
    end
    chk("next_addr", 256'(bus.wr_addr), 256'(model_addr));
    chk("wrap", 256'(bus.wrap_pulse), 256'(exp_wrap));
    chk("busy_done", 256'(bus.busy), 256'(0));
    tick();
    chk("wrap_clr", 256'(bus.wrap_pulse), 256'(0));
  endtask

  initial begin
    bus.fifo_rd_count     = 10'd0;
    bus.fifo_rd_data      = '0;
    bus.wr_ready          = 1'b0;
    bus.wr_done           = 1'b0;
    bus.m_axi_w_handshake = 1'b1;
    #1;
    chk("rst_start", 256'(bus.wr_start), 256'(0));
    chk("rst_busy", 256'(bus.busy), 256'(0));
    chk("rst_wrap", 256'(bus.wrap_pulse), 256'(0));
    chk("rst_addr", 256'(bus.wr_addr), 256'(0));
    chk("rst_rd_en", 256'(bus.fifo_rd_en), 256'(0));
    bus.m_axi_w_handshake = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    tick();

    // basic burst, then an under-filled FIFO that must not start
    run_burst(1'b0, 1'b0);
    bus.fifo_rd_count = 10'd31;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("cnt31_no_start", 256'(bus.wr_start), 256'(0));
    end
    run_burst(1'b0, 1'b0);

    // frame restart while busy at 0x800
    run_burst(1'b0, 1'b1);

    // four bursts covering the region, wrapping on the last
    for (int i = 0; i < 4; i++) run_burst(1'b0, 1'b0);

    // wr_en dropped mid-burst, then held low
    run_burst(1'b1, 1'b0);
    bus.fifo_rd_count = 10'd32;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("en_low_no_start", 256'(bus.wr_start), 256'(0));
    end

    // write master not ready
    wr_en        = 1'b1;
    bus.wr_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("not_ready", 256'(bus.wr_start), 256'(0));
    end
    bus.fifo_rd_count = 10'd0;
    bus.wr_ready      = 1'b1;

    // stray wr_done in IDLE
    bus.wr_done = 1'b1;
    tick();
    bus.wr_done = 1'b0;
    chk("stray_done_addr", 256'(bus.wr_addr), 256'(model_addr));
    chk("stray_done_wrap", 256'(bus.wrap_pulse), 256'(0));

    // frame restart in IDLE blocks the start that cycle and zeroes the address
    bus.fifo_rd_count = 10'd32;
    frame_rst = 1'b1;
    tick();
    frame_rst  = 1'b0;
    model_addr = 29'h0;
    chk("idle_frst_start", 256'(bus.wr_start), 256'(0));
    chk("idle_frst_addr", 256'(bus.wr_addr), 256'(0));
    chk("idle_frst_wrap", 256'(bus.wrap_pulse), 256'(0));
    run_burst(1'b0, 1'b0);

    // asynchronous reset after 10 beats
    bus.fifo_rd_count = 10'd32;
    tick();
    chk("rst_test_start", 256'(bus.wr_start), 256'(1));
    bus.fifo_rd_count = 10'd0;
    tick();
    for (int i = 0; i < 10; i++) begin
      bus.m_axi_w_handshake = 1'b1;
      tick();
    end
    rst = 1'b1;
    #1;
    chk("mid_rst_start", 256'(bus.wr_start), 256'(0));
    chk("mid_rst_busy", 256'(bus.busy), 256'(0));
    chk("mid_rst_addr", 256'(bus.wr_addr), 256'(0));
    chk("mid_rst_wrap", 256'(bus.wrap_pulse), 256'(0));
    for (int i = 0; i < 3; i++) begin
      chk("mid_rst_rd_en", 256'(bus.fifo_rd_en), 256'(0));
      tick();
    end
    rst = 1'b0;
    bus.m_axi_w_handshake = 1'b0;
    model_addr    = 29'h0;
    model_pending = 1'b0;
    tick();
    run_burst(1'b0, 1'b0);

    chk("sb_empty", 256'(addr_q.size()), 256'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1);
  end

endmodule

`default_nettype wire
